// File: rtl/sobel_pkg.sv
// Shared types and constants for the sobelFilter source-SRAM read scheduler.
package sobel_pkg;

   localparam int SOBEL_ADDR_W     = 20;
   localparam int SOBEL_ROW_STRIDE = 256;
   localparam int SOBEL_ROWS       = 4;
   localparam int SOBEL_START_ADDR = 768;
   localparam int SOBEL_END_ADDR   = 65535;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRIME = 3'd1,
      S_FETCH = 3'd2,
      S_HOLD  = 3'd3,
      S_DONE  = 3'd4
   } sched_state_t;

   typedef logic [63:0] pixel_word_t;

endpackage

// File: rtl/sobel_read_sched_if.sv
// Handshake/address bundle between the read scheduler and its host (SRAM port + sobelFilter).
interface sobel_read_sched_if
   import sobel_pkg::*;
#(
   parameter int ADDR_W = SOBEL_ADDR_W
);
   logic              start_en;
   logic              get_next;
   logic [ADDR_W-1:0] read_addr;
   logic              rd_issue;
   logic              q_valid;
   logic [1:0]        q_row;
   logic [7:0]        col_pos;
   logic              busy;
   logic              done;

   modport master (
      input  start_en, get_next,
      output read_addr, rd_issue, q_valid, q_row, col_pos, busy, done
   );

   modport slave (
      output start_en, get_next,
      input  read_addr, rd_issue, q_valid, q_row, col_pos, busy, done
   );
endinterface

// File: rtl/sobel_base_counter.sv
// Column base register: loads the frame start, advances by one column, and
// jumps one row down (back to column 0) when the current column is the last in its row.
module sobel_base_counter
   import sobel_pkg::*;
#(
   parameter int ADDR_W     = SOBEL_ADDR_W,
   parameter int ROW_STRIDE = SOBEL_ROW_STRIDE,
   parameter int START_ADDR = SOBEL_START_ADDR
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic              advance_i,
   output logic [ADDR_W-1:0] base_o
);
   localparam int                COL_W    = $clog2(ROW_STRIDE);
   localparam logic [COL_W-1:0]  COL_LAST = COL_W'(ROW_STRIDE - 1);
   localparam logic [ADDR_W-1:0] START_A  = ADDR_W'(START_ADDR);

   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] base_d;
   logic [ADDR_W-1:0] next_base;
   logic              col_wrap;

   // Wrapping skips a whole row: the window moves down one line as it returns to column 0.
   assign col_wrap  = (base_q[COL_W-1:0] == COL_LAST);
   assign next_base = base_q + (col_wrap ? ADDR_W'(ROW_STRIDE + 1) : ADDR_W'(1));

   always_comb begin
      base_d = base_q;
      if (load_i) begin
         base_d = START_A;
      end else if (advance_i) begin
         base_d = next_base;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base_q <= START_A;
      end else begin
         base_q <= base_d;
      end
   end

   assign base_o = base_q;
endmodule

// File: rtl/sobel_read_sched.sv
// Read-address scheduler walking a ROWS-tall window column by column for sobelFilter.
// Optional SOBEL_SCHED_PRIME_EN inserts one non-issuing PRIME cycle before the first fetch.
module sobel_read_sched
   import sobel_pkg::*;
#(
   parameter int ADDR_W     = SOBEL_ADDR_W,
   parameter int ROW_STRIDE = SOBEL_ROW_STRIDE,
   parameter int ROWS       = SOBEL_ROWS,
   parameter int START_ADDR = SOBEL_START_ADDR,
   parameter int END_ADDR   = SOBEL_END_ADDR
)(
   input  logic               clk,
   input  logic               reset,
   sobel_read_sched_if.master bus
);
   localparam int                ROW_SH   = $clog2(ROW_STRIDE);
   localparam logic [1:0]        LAST_ROW = 2'(ROWS - 1);
   localparam logic [ADDR_W-1:0] START_A  = ADDR_W'(START_ADDR);
   localparam logic [ADDR_W-1:0] END_A    = ADDR_W'(END_ADDR);

   sched_state_t      state_q, state_d;
   logic [1:0]        row_q, row_d;
   logic              busy_q, busy_d;
   logic [ADDR_W-1:0] last_addr_q;
   logic [7:0]        col_pos_q;
   logic              q_valid_q;
   logic [1:0]        q_row_q;

   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] row_off;
   logic [ADDR_W-1:0] addr_c;
   logic [7:0]        col_c;
   logic              base_load;
   logic              base_adv;
   logic              issue_c;
   logic              done_c;

   sobel_base_counter #(
      .ADDR_W     (ADDR_W),
      .ROW_STRIDE (ROW_STRIDE),
      .START_ADDR (START_ADDR)
   ) u_base (
      .clk       (clk),
      .reset     (reset),
      .load_i    (base_load),
      .advance_i (base_adv),
      .base_o    (base)
   );

   assign row_off = ADDR_W'(row_q) << ROW_SH;

   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      busy_d    = busy_q;
      base_load = 1'b0;
      base_adv  = 1'b0;
      issue_c   = 1'b0;
      done_c    = 1'b0;
      addr_c    = last_addr_q;
      col_c     = col_pos_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start_en) begin
               busy_d    = 1'b1;
               row_d     = '0;
               base_load = 1'b1;
`ifdef SOBEL_SCHED_PRIME_EN
               state_d   = S_PRIME;
`else
               state_d   = S_FETCH;
`endif
            end
         end
         S_PRIME: begin
            addr_c  = START_A;
            state_d = S_FETCH;
         end
         S_FETCH: begin
            issue_c = 1'b1;
            addr_c  = base - row_off;
            col_c   = base[7:0];
            // get_next only matters on the window's last row; earlier rows always proceed.
            if (row_q == LAST_ROW) begin
               row_d = '0;
               if (base == END_A) begin
                  state_d = S_DONE;
               end else begin
                  base_adv = 1'b1;
                  if (!bus.get_next) begin
                     state_d = S_HOLD;
                  end
               end
            end else begin
               row_d = row_q + 2'd1;
            end
         end
         S_HOLD: begin
            if (bus.get_next) begin
               state_d = S_FETCH;
            end
         end
         S_DONE: begin
            done_c  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // last_addr_q follows addr_c, so outside FETCH/PRIME the bus simply holds its last value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         row_q       <= '0;
         busy_q      <= 1'b0;
         last_addr_q <= '0;
         col_pos_q   <= '0;
         q_valid_q   <= 1'b0;
         q_row_q     <= '0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         busy_q      <= busy_d;
         last_addr_q <= addr_c;
         col_pos_q   <= col_c;
         q_valid_q   <= issue_c;
         q_row_q     <= row_q;
      end
   end

   assign bus.read_addr = addr_c;
   assign bus.rd_issue  = issue_c;
   assign bus.q_valid   = q_valid_q;
   assign bus.q_row     = q_row_q;
   assign bus.col_pos   = col_c;
   assign bus.busy      = busy_q;
   assign bus.done      = done_c;
endmodule

// File: tb/tb_sobel_read_sched.sv
// Self-checking bench for sobel_read_sched: vector table, corner sequences and randomized frames.
module tb_sobel_read_sched;
   localparam int AW    = 20;
   localparam int END_A = 1300;
   localparam int END_B = 769;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   sobel_read_sched_if #(.ADDR_W(AW)) bus_a ();
   sobel_read_sched_if #(.ADDR_W(AW)) bus_b ();

   sobel_read_sched #(
      .ADDR_W(AW), .ROW_STRIDE(256), .ROWS(4), .START_ADDR(768), .END_ADDR(END_A)
   ) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a)
   );

   sobel_read_sched #(
      .ADDR_W(AW), .ROW_STRIDE(256), .ROWS(4), .START_ADDR(768), .END_ADDR(END_B)
   ) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b)
   );

   typedef struct {
      int addr;
      int issue;
      int qv;
      int qr;
      int col;
   } vec_t;

   vec_t tbl[9];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   exp_reads[$];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Reference read list built straight from the window-walk rules.
   function automatic void fill_reads(input int end_addr);
      int b;
      exp_reads.delete();
      b = 768;
      forever begin
         for (int r = 0; r < 4; r++) exp_reads.push_back(b - r * 256);
         if (b == end_addr) break;
         b = ((b % 256) == 255) ? b + 257 : b + 1;
      end
   endfunction

   // Pulse start on A; returns at the negedge of the first FETCH cycle (unchecked).
   task automatic start_a();
      @(negedge clk);
      bus_a.start_en = 1'b1;
      @(negedge clk);
      bus_a.start_en = 1'b0;
`ifdef SOBEL_SCHED_PRIME_EN
      chk("prime_addr", int'(bus_a.read_addr), 768);
      chk("prime_issue", int'(bus_a.rd_issue), 0);
      @(negedge clk);
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic run_random_frame(input int fno);
      int idx = 0;
      bit waiting = 1'b0;
      bit prev_issue = 1'b0;
      int prev_row = 0;
      int last = 0;
      bit fin = 1'b0;
      int stalls = 0;
      fill_reads(END_A);
      start_a();
      for (int cyc = 0; cyc < 10000 && !fin; cyc++) begin
         chk("rnd_busy", int'(bus_a.busy), 1);
         chk("rnd_qvalid", int'(bus_a.q_valid), int'(prev_issue));
         if (prev_issue) chk("rnd_qrow", int'(bus_a.q_row), prev_row);
         if (idx == exp_reads.size()) begin
            chk("rnd_done", int'(bus_a.done), 1);
            chk("rnd_done_issue", int'(bus_a.rd_issue), 0);
            chk("rnd_done_addr", int'(bus_a.read_addr), last);
            fin = 1'b1;
            bus_a.start_en = 1'b0;
         end else begin
            chk("rnd_nodone", int'(bus_a.done), 0);
            if (waiting) begin
               chk("rnd_hold_issue", int'(bus_a.rd_issue), 0);
               chk("rnd_hold_addr", int'(bus_a.read_addr), last);
               chk("rnd_hold_col", int'(bus_a.col_pos), last % 256);
            end else begin
               chk("rnd_issue", int'(bus_a.rd_issue), 1);
               chk("rnd_addr", int'(bus_a.read_addr), exp_reads[idx]);
               chk("rnd_col", int'(bus_a.col_pos), exp_reads[idx] % 256);
            end
            bus_a.get_next = 1'($urandom_range(0, 1));
            bus_a.start_en = ($urandom_range(0, 7) == 0);
            if (waiting) begin
               if (bus_a.get_next) waiting = 1'b0;
               prev_issue = 1'b0;
               stalls++;
            end else begin
               prev_row   = idx % 4;
               last       = exp_reads[idx];
               prev_issue = 1'b1;
               idx++;
               if (prev_row == 3 && idx < exp_reads.size()) waiting = !bus_a.get_next;
            end
         end
         @(negedge clk);
      end
      if (!fin) chk("rnd_timeout", 0, 1);
      chk("rnd_idle_busy", int'(bus_a.busy), 0);
      chk("rnd_idle_done", int'(bus_a.done), 0);
      chk("rnd_idle_qvalid", int'(bus_a.q_valid), 0);
      $display("frame %0d: %0d reads, %0d hold cycles", fno, idx, stalls);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int found;
      int wrap_addr[8];
      int wrap_col[8];
      int nreads;
      int ndone;

      bus_a.start_en = 1'b0;
      bus_a.get_next = 1'b1;
      bus_b.start_en = 1'b0;
      bus_b.get_next = 1'b1;

      tbl[0] = '{768, 1, 0, 0, 0};
      tbl[1] = '{512, 1, 1, 0, 0};
      tbl[2] = '{256, 1, 1, 1, 0};
      tbl[3] = '{  0, 1, 1, 2, 0};
      tbl[4] = '{769, 1, 1, 3, 1};
      tbl[5] = '{513, 1, 1, 0, 1};
      tbl[6] = '{257, 1, 1, 1, 1};
      tbl[7] = '{  1, 1, 1, 2, 1};
      tbl[8] = '{770, 1, 1, 3, 2};
      wrap_addr = '{1023, 767, 511, 255, 1280, 1024, 768, 512};
      wrap_col  = '{255, 255, 255, 255, 0, 0, 0, 0};

      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_addr", int'(bus_a.read_addr), 0);
      chk("rst_issue", int'(bus_a.rd_issue), 0);
      chk("rst_qvalid", int'(bus_a.q_valid), 0);
      chk("rst_qrow", int'(bus_a.q_row), 0);
      chk("rst_col", int'(bus_a.col_pos), 0);
      chk("rst_busy", int'(bus_a.busy), 0);
      chk("rst_done", int'(bus_a.done), 0);
      reset = 1'b1;

      // Back-to-back columns with get_next tied high.
      start_a();
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("vec%0d_addr", i), int'(bus_a.read_addr), tbl[i].addr);
         chk($sformatf("vec%0d_issue", i), int'(bus_a.rd_issue), tbl[i].issue);
         chk($sformatf("vec%0d_qvalid", i), int'(bus_a.q_valid), tbl[i].qv);
         chk($sformatf("vec%0d_qrow", i), int'(bus_a.q_row), tbl[i].qr);
         chk($sformatf("vec%0d_col", i), int'(bus_a.col_pos), tbl[i].col);
         $display("vec %0d: addr=%0d issue=%0b q_valid=%0b q_row=%0d col=%0d", i,
                  bus_a.read_addr, bus_a.rd_issue, bus_a.q_valid, bus_a.q_row, bus_a.col_pos);
         @(negedge clk);
      end

      // Column wrap at base 1023.
      found = 0;
      for (int k = 0; k < 2000; k++) begin
         if (bus_a.rd_issue && bus_a.read_addr == 20'd1023) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      chk("wrap_reached", found, 1);
      for (int j = 0; j < 8; j++) begin
         chk($sformatf("wrap%0d_addr", j), int'(bus_a.read_addr), wrap_addr[j]);
         chk($sformatf("wrap%0d_issue", j), int'(bus_a.rd_issue), 1);
         chk($sformatf("wrap%0d_col", j), int'(bus_a.col_pos), wrap_col[j]);
         $display("wrap %0d: addr=%0d col=%0d", j, bus_a.read_addr, bus_a.col_pos);
         if (j == 7) bus_a.start_en = 1'b1;
         @(negedge clk);
      end
      bus_a.start_en = 1'b0;
      chk("start_ignored_addr", int'(bus_a.read_addr), 1281);
      chk("start_ignored_busy", int'(bus_a.busy), 1);
      $display("start during fetch: addr=%0d", bus_a.read_addr);

      // Asynchronous reset in the middle of a column.
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("arst_addr", int'(bus_a.read_addr), 0);
      chk("arst_issue", int'(bus_a.rd_issue), 0);
      chk("arst_qvalid", int'(bus_a.q_valid), 0);
      chk("arst_qrow", int'(bus_a.q_row), 0);
      chk("arst_col", int'(bus_a.col_pos), 0);
      chk("arst_busy", int'(bus_a.busy), 0);
      chk("arst_done", int'(bus_a.done), 0);
      $display("async reset mid-column applied");
      @(negedge clk);
      reset = 1'b1;

      // Restart, then stall on the last row of base 770.
      start_a();
      chk("restart_addr", int'(bus_a.read_addr), 768);
      chk("restart_issue", int'(bus_a.rd_issue), 1);
      found = 0;
      for (int k = 0; k < 100; k++) begin
         if (bus_a.rd_issue && bus_a.read_addr == 20'd2) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      chk("stall_reached", found, 1);
      bus_a.get_next = 1'b0;
      for (int h = 0; h < 5; h++) begin
         @(negedge clk);
         chk($sformatf("hold%0d_issue", h), int'(bus_a.rd_issue), 0);
         chk($sformatf("hold%0d_addr", h), int'(bus_a.read_addr), 2);
         if (h == 0) begin
            chk("hold_qvalid", int'(bus_a.q_valid), 1);
            chk("hold_qrow", int'(bus_a.q_row), 3);
         end
         $display("hold %0d: addr=%0d issue=%0b", h, bus_a.read_addr, bus_a.rd_issue);
      end
      bus_a.get_next = 1'b1;
      @(negedge clk);
      chk("resume_addr", int'(bus_a.read_addr), 771);
      chk("resume_issue", int'(bus_a.rd_issue), 1);
      $display("resume: addr=%0d", bus_a.read_addr);
      do_reset();

      for (int f = 0; f < 2; f++) run_random_frame(f);
      bus_a.get_next = 1'b1;

      // Short frame on B: two columns, single done pulse, then restart.
      fill_reads(END_B);
      @(negedge clk);
      bus_b.start_en = 1'b1;
      @(negedge clk);
      bus_b.start_en = 1'b0;
      nreads = 0;
      ndone  = 0;
      for (int c = 0; c < 30; c++) begin
         if (bus_b.rd_issue) begin
            if (nreads < exp_reads.size())
               chk($sformatf("short_rd%0d", nreads), int'(bus_b.read_addr), exp_reads[nreads]);
            nreads++;
         end
         if (bus_b.done) ndone++;
         @(negedge clk);
      end
      chk("short_reads", nreads, 8);
      chk("short_done_pulses", ndone, 1);
      chk("short_busy_fall", int'(bus_b.busy), 0);
      $display("short frame: reads=%0d done_pulses=%0d", nreads, ndone);
      bus_b.start_en = 1'b1;
      @(negedge clk);
      bus_b.start_en = 1'b0;
      found = 0;
      for (int k = 0; k < 5; k++) begin
         if (bus_b.rd_issue) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      chk("short_restart_seen", found, 1);
      chk("short_restart_addr", int'(bus_b.read_addr), 768);
      $display("short frame restart: addr=%0d", bus_b.read_addr);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
